phoenix_vec_regfile_mt: RTL and testbench

- Parametrised, multi-threaded vector register file for the rfPhoenix vector datapath.
- Generalises lane count, lane width, thread count, register count and read-port count.
- Adds:
  - registered reads with write-to-read bypass;
  - a post-reset clear sequencer;
  - a per-thread clear command with req/ack handshake.
- Sits between the register-read stage and the writeback stage.

---
 rtl/phoenix_vec_regfile_mt_pkg.sv | 18 +
 rtl/phoenix_vrf_lane_bank.sv | 95 +++++++++
 rtl/phoenix_vec_regfile_mt.sv | 116 +++++++++++
 tb/tb_phoenix_vec_regfile_mt.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phoenix_vec_regfile_mt_pkg.sv
// Shared types, state encoding and helpers for the multi-threaded vector register file.
package phoenix_vec_regfile_mt_pkg;

  localparam int VRF_NRP    = 5;
  localparam int VRF_LANE_W = 32;
  localparam int VRF_TW     = 2;
  localparam int VRF_RW     = 6;

  typedef logic [VRF_LANE_W-1:0]      vreg_lane_t;
  typedef logic [VRF_TW+VRF_RW-1:0]   vreg_addr_t;

  typedef enum logic [1:0] {INIT, RUN, TCLR} vrf_state_t;

  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/phoenix_vrf_lane_bank.sv
// One lane, one read port: byte-enabled user write, zero-write from the sequencer, registered read with bypass.
// Per-byte even parity is stored and checked when PHOENIX_VREG_PARITY_EN is defined.
module phoenix_vrf_lane_bank
  import phoenix_vec_regfile_mt_pkg::*;
#(
  parameter int LANE_W = 32,
  parameter int AW     = 8,
  localparam int BPL   = LANE_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [BPL-1:0]    i_wmask,
  input  logic [LANE_W-1:0] i_wdata,
  input  logic              i_swe,
  input  logic [AW-1:0]     i_saddr,
  input  logic [AW-1:0]     i_raddr,
  input  logic              i_rzero,
  output logic [LANE_W-1:0] o_rdata,
  output logic              o_perr
);
  localparam int DEPTH = 1 << AW;

  logic [LANE_W-1:0] r_mem [DEPTH];
  logic [LANE_W-1:0] r_rdata;
  logic              r_perr;
  logic [LANE_W-1:0] w_old;
  logic [LANE_W-1:0] w_merged;
  logic              w_hit;
  logic              w_shit;
  logic              w_perr;

  assign w_old  = r_mem[i_raddr];
  assign w_hit  = i_we && (i_waddr == i_raddr);
  assign w_shit = i_swe && (i_saddr == i_raddr);

  genvar gi;
  generate
    for (gi = 0; gi < BPL; gi++) begin : g_byte
      assign w_merged[gi*8 +: 8] = w_shit ? 8'h00 :
                                   (w_hit && i_wmask[gi]) ? i_wdata[gi*8 +: 8] : w_old[gi*8 +: 8];
    end
  endgenerate

  // The sequencer and user writes never target the same address in one cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BPL; b++) begin
        if (i_wmask[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_swe) r_mem[i_saddr] <= '0;
  end

`ifdef PHOENIX_VREG_PARITY_EN
  logic [BPL-1:0] r_par [DEPTH];
  logic [BPL-1:0] w_par_new;
  logic [BPL-1:0] w_par_chk;

  generate
    for (gi = 0; gi < BPL; gi++) begin : g_par
      assign w_par_new[gi] = byte_par(i_wdata[gi*8 +: 8]);
      assign w_par_chk[gi] = byte_par(w_old[gi*8 +: 8]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BPL; b++) begin
        if (i_wmask[b]) r_par[i_waddr][b] <= w_par_new[b];
      end
    end
    if (i_swe) r_par[i_saddr] <= '0;
  end

  assign w_perr = !(w_hit || w_shit) && (r_par[i_raddr] != w_par_chk);
`else
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst || i_rzero) begin
      r_rdata <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_rdata <= w_merged;
      r_perr  <= w_perr;
    end
  end

  assign o_rdata = r_rdata;
  assign o_perr  = r_perr;

endmodule

// File: rtl/phoenix_vec_regfile_mt.sv
// Multi-threaded vector register file: post-reset clear, per-thread clear handshake, NRP registered read ports.
// Optional per-byte parity checking is enabled by defining PHOENIX_VREG_PARITY_EN.
module phoenix_vec_regfile_mt
  import phoenix_vec_regfile_mt_pkg::*;
#(
  parameter int NLANES   = 16,
  parameter int LANE_W   = 32,
  parameter int NTHREADS = 4,
  parameter int NREGS    = 64,
  parameter int NRP      = VRF_NRP,
  localparam int TW      = $clog2(NTHREADS),
  localparam int RW      = $clog2(NREGS),
  localparam int BPL     = LANE_W / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [TW-1:0]                wthread,
  input  logic [RW-1:0]                wa,
  input  logic [NLANES*BPL-1:0]        wmask,
  input  logic [NLANES*LANE_W-1:0]     i,
  input  logic [TW-1:0]                rthread,
  input  logic [NRP*RW-1:0]            ra,
  output logic [NRP*NLANES*LANE_W-1:0] o,
  input  logic                         clr_req,
  input  logic [TW-1:0]                clr_thread,
  output logic                         clr_ack,
  output logic                         rdy,
  output logic [NRP-1:0]               perr
);
  localparam int AW = TW + RW;

  vrf_state_t          r_state;
  logic [AW-1:0]       r_cnt;
  logic [TW-1:0]       r_clr_thread;
  logic                r_clr_ack;
  logic                r_rdy;

  logic                w_swe;
  logic [AW-1:0]       w_saddr;
  logic                w_uwe;
  logic                w_rzero;
  logic [NRP*NLANES-1:0] w_lperr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= INIT;
      r_cnt        <= '0;
      r_clr_thread <= '0;
      r_clr_ack    <= 1'b0;
      r_rdy        <= 1'b0;
    end else begin
      r_clr_ack <= 1'b0;
      case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state <= RUN;
            r_rdy   <= 1'b1;
          end
        end
        RUN: begin
          if (clr_req) begin
            r_state      <= TCLR;
            r_clr_thread <= clr_thread;
            r_cnt        <= '0;
          end
        end
        TCLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt[RW-1:0]) begin
            r_state   <= RUN;
            r_clr_ack <= 1'b1;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // A thread being cleared rejects user writes, so the clear always wins.
  assign w_swe   = rst && (r_state == INIT || r_state == TCLR);
  assign w_saddr = (r_state == TCLR) ? {r_clr_thread, r_cnt[RW-1:0]} : r_cnt;
  assign w_uwe   = rst && wr && r_rdy && !(r_state == TCLR && wthread == r_clr_thread);
  assign w_rzero = (r_state == INIT);

  genvar gi, gl;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_port
      for (gl = 0; gl < NLANES; gl++) begin : g_lane
        phoenix_vrf_lane_bank #(
          .LANE_W(LANE_W),
          .AW    (AW)
        ) u_bank (
          .clk    (clk),
          .rst    (rst),
          .i_we   (w_uwe),
          .i_waddr({wthread, wa}),
          .i_wmask(wmask[gl*BPL +: BPL]),
          .i_wdata(i[gl*LANE_W +: LANE_W]),
          .i_swe  (w_swe),
          .i_saddr(w_saddr),
          .i_raddr({rthread, ra[gi*RW +: RW]}),
          .i_rzero(w_rzero),
          .o_rdata(o[(gi*NLANES + gl)*LANE_W +: LANE_W]),
          .o_perr (w_lperr[gi*NLANES + gl])
        );
      end
      assign perr[gi] = |w_lperr[gi*NLANES +: NLANES];
    end
  endgenerate

  assign clr_ack = r_clr_ack;
  assign rdy     = r_rdy;

endmodule

// File: tb/tb_phoenix_vec_regfile_mt.sv
// Bench for phoenix_vec_regfile_mt: directed vector table, clear/reset sequences and random traffic vs a reference model.
module tb_phoenix_vec_regfile_mt;
  localparam int NLANES   = 16;
  localparam int LANE_W   = 32;
  localparam int NTHREADS = 4;
  localparam int NREGS    = 64;
  localparam int NRP      = 5;
  localparam int TW       = 2;
  localparam int RW       = 6;
  localparam int BPL      = 4;
  localparam int DW       = NLANES * LANE_W;
  localparam int MW       = NLANES * BPL;
  localparam int NADDR    = NTHREADS * NREGS;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr;
  logic [TW-1:0]       wthread;
  logic [RW-1:0]       wa;
  logic [MW-1:0]       wmask;
  logic [DW-1:0]       i;
  logic [TW-1:0]       rthread;
  logic [NRP*RW-1:0]   ra;
  logic [NRP*DW-1:0]   o;
  logic                clr_req;
  logic [TW-1:0]       clr_thread;
  logic                clr_ack;
  logic                rdy;
  logic [NRP-1:0]      perr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  phoenix_vec_regfile_mt dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .wthread   (wthread),
    .wa        (wa),
    .wmask     (wmask),
    .i         (i),
    .rthread   (rthread),
    .ra        (ra),
    .o         (o),
    .clr_req   (clr_req),
    .clr_thread(clr_thread),
    .clr_ack   (clr_ack),
    .rdy       (rdy),
    .perr      (perr)
  );

  // Reference model: whole-register contents per flat {thread,reg} plus the clear in progress.
  logic [DW-1:0] model [NADDR];
  bit            m_clr_active;
  int            m_clr_thread;
  int            m_clr_idx;

  typedef struct {
    bit          we;
    int          wt;
    int          wreg;
    int          wl;
    logic [3:0]  lm;
    logic [31:0] ld;
    int          rt;
    int          rr;
    int          rp;
    int          rl;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic rand_reads();
    rthread = TW'($urandom);
    for (int p = 0; p < NRP; p++) ra[p*RW +: RW] = RW'($urandom);
  endtask

  // One clock of traffic with the current inputs, checked against the model.
  task automatic cycle();
    logic [DW-1:0] exp_o [NRP];
    int  waddr, saddr, raddr;
    bit  uwe, swe, ack_next, was_active;
    was_active = m_clr_active;
    swe   = m_clr_active;
    saddr = m_clr_thread * NREGS + m_clr_idx;
    uwe   = wr && !(m_clr_active && int'(wthread) == m_clr_thread);
    waddr = int'(wthread) * NREGS + int'(wa);
    for (int p = 0; p < NRP; p++) begin
      raddr = int'(rthread) * NREGS + int'(ra[p*RW +: RW]);
      exp_o[p] = model[raddr];
      if (uwe && waddr == raddr) exp_o[p] = merge(exp_o[p], i, wmask);
      if (swe && saddr == raddr) exp_o[p] = '0;
    end
    if (uwe) model[waddr] = merge(model[waddr], i, wmask);
    if (swe) model[saddr] = '0;
    ack_next = m_clr_active && m_clr_idx == NREGS - 1;
    if (was_active) begin
      if (m_clr_idx == NREGS - 1) m_clr_active = 1'b0;
      else m_clr_idx++;
    end else if (clr_req) begin
      m_clr_active = 1'b1;
      m_clr_thread = int'(clr_thread);
      m_clr_idx    = 0;
    end
    @(posedge clk); #1;
    for (int p = 0; p < NRP; p++) check($sformatf("o_port%0d", p), o[p*DW +: DW], exp_o[p]);
    check("rdy", DW'(rdy), DW'(1));
    check("clr_ack", DW'(clr_ack), DW'(ack_next));
    check("perr", DW'(perr), '0);
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b0; wr = 1'b0; clr_req = 1'b0;
    @(posedge clk); #1;
    check("rst_rdy", DW'(rdy), '0);
    check("rst_clr_ack", DW'(clr_ack), '0);
    check("rst_perr", DW'(perr), '0);
    for (int p = 0; p < NRP; p++) check($sformatf("rst_o_port%0d", p), o[p*DW +: DW], '0);
    rst = 1'b1;
    for (int a = 0; a < NADDR; a++) model[a] = '0;
    m_clr_active = 1'b0;
    n = 0;
    while (!rdy && n < 1000) begin
      rand_reads();
      @(posedge clk); #1;
      n++;
      if (!rdy) check("init_o_port0", o[DW-1:0], '0);
    end
    check("init_cycles", DW'(n), DW'(NADDR));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t0_val, t3_val;
    int n;

    tbl[0] = '{1'b1, 1, 5, 0, 4'hF, 32'hDEADBEEF, 1, 5, 2, 0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1, 5, 0, 4'h3, 32'h00001234, 1, 5, 2, 0, 32'hDEAD1234};
    tbl[2] = '{1'b0, 0, 0, 0, 4'h0, 32'h00000000, 1, 5, 2, 0, 32'hDEAD1234};
    tbl[3] = '{1'b1, 2, 7, 3, 4'hF, 32'h11223344, 1, 5, 0, 0, 32'hDEAD1234};
    tbl[4] = '{1'b1, 2, 7, 3, 4'h8, 32'hAA000000, 2, 7, 1, 3, 32'hAA223344};
    tbl[5] = '{1'b0, 0, 0, 0, 4'h0, 32'h00000000, 2, 7, 4, 3, 32'hAA223344};
    tbl[6] = '{1'b1, 0, 0, 2, 4'h0, 32'hFFFFFFFF, 0, 0, 3, 2, 32'h00000000};
    tbl[7] = '{1'b0, 0, 0, 0, 4'h0, 32'h00000000, 1, 5, 1, 1, 32'h00000000};

    rst = 1'b0; wr = 1'b0; wthread = '0; wa = '0; wmask = '0; i = '0;
    rthread = '0; ra = '0; clr_req = 1'b0; clr_thread = '0;
    m_clr_active = 1'b0; m_clr_thread = 0; m_clr_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Freshly initialised file reads zero everywhere.
    wr = 1'b0;
    repeat (8) begin rand_reads(); cycle(); end

    for (int k = 0; k < 8; k++) begin
      wr = tbl[k].we;
      wthread = TW'(tbl[k].wt);
      wa = RW'(tbl[k].wreg);
      wmask = '0;
      wmask[tbl[k].wl*BPL +: BPL] = tbl[k].lm;
      i = rand_data();
      i[tbl[k].wl*LANE_W +: LANE_W] = tbl[k].ld;
      rand_reads();
      rthread = TW'(tbl[k].rt);
      ra[tbl[k].rp*RW +: RW] = RW'(tbl[k].rr);
      cycle();
      check($sformatf("vec%0d_lane", k), DW'(o[tbl[k].rp*DW + tbl[k].rl*LANE_W +: LANE_W]), DW'(tbl[k].exp));
    end

    repeat (200) begin
      wr = 1'($urandom);
      wthread = TW'($urandom);
      wa = RW'($urandom_range(0, 7));
      wmask = {$urandom, $urandom};
      i = rand_data();
      rthread = TW'($urandom);
      for (int p = 0; p < NRP; p++) ra[p*RW +: RW] = RW'($urandom_range(0, 7));
      cycle();
    end

    // Fill threads 0 and 3, then clear thread 3 with concurrent writes to r9 of both threads.
    wr = 1'b1; wmask = '1;
    for (int t = 0; t < NTHREADS; t += 3) begin
      for (int r = 0; r < NREGS; r++) begin
        wthread = TW'(t); wa = RW'(r); i = rand_data(); rand_reads(); cycle();
      end
    end
    t0_val = rand_data();
    t3_val = rand_data();
    clr_thread = 2'd3; clr_req = 1'b1; n = 0;
    while (n < 200) begin
      rand_reads();
      wr = 1'b0;
      if (n == 10) begin wr = 1'b1; wthread = 2'd0; wa = 6'd9; wmask = '1; i = t0_val; end
      if (n == 11) begin wr = 1'b1; wthread = 2'd3; wa = 6'd9; wmask = '1; i = t3_val; end
      cycle();
      n++;
      if (clr_ack) break;
    end
    clr_req = 1'b0; wr = 1'b0;
    check("clr_ack_latency", DW'(n), DW'(NREGS + 1));

    for (int t = 3; t >= 0; t -= 3) begin
      for (int r = 0; r < NREGS; r += NRP) begin
        rthread = TW'(t);
        for (int p = 0; p < NRP; p++) ra[p*RW +: RW] = RW'((r + p) % NREGS);
        cycle();
      end
    end
    rthread = 2'd3; ra[RW-1:0] = 6'd9; cycle();
    check("t3_r9_cleared", o[DW-1:0], '0);
    rthread = 2'd0; ra[RW-1:0] = 6'd9; cycle();
    check("t0_r9_written", o[DW-1:0], t0_val);

    // Reset 30 cycles into a clear of thread 0.
    clr_thread = 2'd0; clr_req = 1'b1;
    repeat (31) begin rand_reads(); cycle(); end
    do_reset();
    repeat (8) begin rand_reads(); cycle(); end

    wr = 1'b1; wthread = 2'd0; wa = 6'd4; wmask = '1; i = rand_data(); rand_reads(); cycle();
    wr = 1'b0; rthread = 2'd0;
    for (int p = 0; p < NRP; p++) ra[p*RW +: RW] = (p < 2) ? 6'd4 : 6'd5;
    cycle();
`ifdef PHOENIX_VREG_PARITY_EN
    dut.g_port[0].g_lane[1].u_bank.r_mem[4][17] = ~dut.g_port[0].g_lane[1].u_bank.r_mem[4][17];
    dut.g_port[1].g_lane[1].u_bank.r_mem[4][17] = ~dut.g_port[1].g_lane[1].u_bank.r_mem[4][17];
    dut.g_port[2].g_lane[1].u_bank.r_mem[4][17] = ~dut.g_port[2].g_lane[1].u_bank.r_mem[4][17];
    dut.g_port[3].g_lane[1].u_bank.r_mem[4][17] = ~dut.g_port[3].g_lane[1].u_bank.r_mem[4][17];
    dut.g_port[4].g_lane[1].u_bank.r_mem[4][17] = ~dut.g_port[4].g_lane[1].u_bank.r_mem[4][17];
    @(posedge clk); #1;
    check("parity_perr", DW'(perr), DW'(5'b00011));
    model[4][LANE_W + 17] = ~model[4][LANE_W + 17];
    check("parity_data", o[DW-1:0], model[4]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
